// File: rtl/pipe_catch_fifo.sv
// Catch buffer for the output of a fixed-latency, non-stallable pipeline. slowDown warns upstream early enough that in-flight words always fit.
// Optional sticky write-when-full detection: define PIPE_CATCH_OVERFLOW_CHECK_EN.
module pipe_catch_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int PIPE_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         writeValid,
  input  logic [WIDTH-1:0]             dataIn,
  output logic                         slowDown,
  input  logic                         readRequest,
  output logic [WIDTH-1:0]             dataOut,
  output logic                         dataOutValid,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   usedw,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - PIPE_LATENCY - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_slow;
  logic [WIDTH-1:0] r_dout_p1;
  logic             r_vld_p1;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [CW-1:0]    w_count_nxt;

  // A full buffer still accepts a write when a read frees a slot in the same cycle.
  assign w_rd_acc    = readRequest && (r_count != '0);
  assign w_wr_acc    = writeValid && ((r_count != FULL) || w_rd_acc);
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_slow    <= 1'b0;
      r_dout_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rptr    <= r_rptr + AW'(1);
        r_dout_p1 <= r_mem[r_rptr];
      end
      r_vld_p1 <= w_rd_acc;
      r_count  <= w_count_nxt;
      r_slow   <= (w_count_nxt >= THRESH);
    end
  end

`ifdef PIPE_CATCH_OVERFLOW_CHECK_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (writeValid && !w_wr_acc) begin
      r_ovf <= 1'b1;
    end
  end

  assign overflow = r_ovf;
`else
  assign overflow = 1'b0;
`endif

  assign slowDown     = r_slow;
  assign dataOut      = r_dout_p1;
  assign dataOutValid = r_vld_p1;
  assign usedw        = r_count;
  assign empty        = (r_count == '0);

endmodule
